// File: rtl/bias_ctrl_pkg.sv
// Shared sizing, types and helpers for the bias fetch controller.
// Defining BIAS_ROM_LAT2_EN selects a ROM with registered output (ROM_LAT=2, FIFO_DEPTH=3).
package bias_ctrl_pkg;

    localparam int BIAS_W = 24;
    localparam int ADDR_W = 3;
    localparam int NUM_CH = 6;

`ifdef BIAS_ROM_LAT2_EN
    localparam int ROM_LAT = 2;
`else
    localparam int ROM_LAT = 1;
`endif

    // One slot per read in the ROM pipe plus one at the output keeps a beat per cycle.
    localparam int FIFO_DEPTH = ROM_LAT + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef logic signed [BIAS_W-1:0] bias_word_t;

    typedef struct packed {
        bias_word_t        data;
        logic [ADDR_W-1:0] idx;
    } bias_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } bias_fsm_e;

    function automatic logic [ADDR_W-1:0] next_ch(input logic [ADDR_W-1:0] ch);
        return (ch == ADDR_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] reduce_ch(input logic [ADDR_W-1:0] ch);
        return ADDR_W'(32'(ch) % NUM_CH);
    endfunction

endpackage

// File: rtl/bias_skid_fifo.sv
// Small circular FIFO of bias beats; push and pop may coincide at any occupancy, including full.
module bias_skid_fifo
    import bias_ctrl_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  bias_beat_t      wr_beat,
    input  logic            pop,
    output bias_beat_t      head,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    bias_beat_t    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, the write slot is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_beat;
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop));

endmodule

// File: rtl/bias_fetch_ctrl.sv
// Fetches one layer's biases from the ROM and streams them out tagged with channel index.
// BIAS_ROM_LAT2_EN (in bias_ctrl_pkg) switches to the two-cycle registered-output ROM.
module bias_fetch_ctrl
    import bias_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] ch_base,
    input  logic [ADDR_W:0]   ch_count,
    output logic              busy,
    output logic              done,
    output logic              rom_cena,
    output logic [ADDR_W-1:0] rom_aa,
    input  bias_word_t        rom_qa,
    output logic              bias_valid,
    input  logic              bias_ready,
    output bias_word_t        bias_data,
    output logic [ADDR_W-1:0] bias_idx
);

    localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W + 1)'(1);

    bias_fsm_e         state;
    bias_fsm_e         state_n;
    logic              issue;
    int                occ;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] last_aa;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   out_left;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    bias_beat_t        wr_beat;
    bias_beat_t        head;
    logic              vld_p0;
    logic [ADDR_W-1:0] idx_p0;
`ifdef BIAS_ROM_LAT2_EN
    logic              vld_p1;
    logic [ADDR_W-1:0] idx_p1;
`endif

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        // Credit counts the slot freed by this cycle's pop so steady state keeps one read per cycle.
        occ     = int'(fifo_count) + int'(inflight) - int'(pop);
        unique case (state)
            IDLE: begin
                if (start) state_n = (ch_count == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (occ < FIFO_DEPTH && !(fifo_full && !pop)) begin
                    issue = 1'b1;
                    if (issue_left == ONE_CNT) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 && fifo_count == CNT_W'(pop) &&
                    (out_left == '0 || (out_left == ONE_CNT && pop)))
                    state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy       = (state == FETCH) || (state == DRAIN);
    assign done       = (state == DONE);
    assign rom_cena   = !issue;
    assign rom_aa     = issue ? next_addr : last_aa;
    assign bias_valid = !fifo_empty;
    assign pop        = !fifo_empty && bias_ready;
    assign bias_data  = fifo_empty ? '0 : head.data;
    assign bias_idx   = fifo_empty ? '0 : head.idx;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            next_addr  <= '0;
            last_aa    <= '0;
            issue_left <= '0;
            out_left   <= '0;
            inflight   <= '0;
            vld_p0     <= 1'b0;
`ifdef BIAS_ROM_LAT2_EN
            vld_p1     <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                next_addr  <= reduce_ch(ch_base);
                issue_left <= ch_count;
                out_left   <= ch_count;
            end
            if (issue) begin
                next_addr  <= next_ch(next_addr);
                last_aa    <= next_addr;
                issue_left <= issue_left - 1'b1;
            end
            if (pop && out_left != '0) out_left <= out_left - 1'b1;
            inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
            vld_p0   <= issue;
`ifdef BIAS_ROM_LAT2_EN
            vld_p1   <= vld_p0;
`endif
        end
    end

    // p0: read issued last cycle; p1 (registered ROM): issued two cycles ago
    always_ff @(posedge clk) begin
        if (issue) idx_p0 <= next_addr;
`ifdef BIAS_ROM_LAT2_EN
        idx_p1 <= idx_p0;
`endif
    end

`ifdef BIAS_ROM_LAT2_EN
    assign push         = vld_p1;
    assign wr_beat.idx  = idx_p1;
`else
    assign push         = vld_p0;
    assign wr_beat.idx  = idx_p0;
`endif
    assign wr_beat.data = rom_qa;

    bias_skid_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push),
        .wr_beat (wr_beat),
        .pop     (pop),
        .head    (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
